// File: rtl/axi4l_regbank_if.sv
// AXI4-Lite signal bundle between an interconnect master and the register-bank slave.
// Widths are set by the instantiating parent and must match the slave's parameters.
interface axi4l_regbank_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axi4l_regbank.sv
// Parametrised AXI4-Lite register bank: per-register RW control, RO status or W1C sticky
// events, with per-register write/read strobes to the fabric.
module axi4l_regbank #(
  parameter int C_DATA_WIDTH = 32,
  parameter int C_ADDR_WIDTH = 12,
  parameter int C_NUM_REGS   = 8,
  parameter logic [C_NUM_REGS-1:0] C_RO_MASK  = '0,
  parameter logic [C_NUM_REGS-1:0] C_W1C_MASK = '0,
  parameter logic [C_NUM_REGS*C_DATA_WIDTH-1:0] C_RESET_VALUE = '0
) (
  input  logic                               aclk,
  input  logic                               areset,
  axi4l_regbank_if.slave                     s_axi,
  output logic [C_NUM_REGS*C_DATA_WIDTH-1:0] reg_out,
  input  logic [C_NUM_REGS*C_DATA_WIDTH-1:0] reg_in,
  input  logic [C_NUM_REGS*C_DATA_WIDTH-1:0] evt_set,
  output logic [C_NUM_REGS-1:0]              reg_wr_pulse,
  output logic [C_NUM_REGS-1:0]              reg_rd_pulse,
  output logic [2:0]                         dbg_wr_state,
  output logic [1:0]                         dbg_rd_state
);
  localparam int DW  = C_DATA_WIDTH;
  localparam int SW  = C_DATA_WIDTH / 8;
  localparam int LSB = $clog2(SW);
  localparam int IW  = C_ADDR_WIDTH - LSB;
  localparam logic [IW:0] NUM_REGS_EXT = (IW+1)'(C_NUM_REGS);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {WR_RST, WR_IDLE, WR_ADDR, WR_DATA, WR_RESP} wr_state_t;
  typedef enum logic [1:0] {RD_RST, RD_IDLE, RD_DATA} rd_state_t;

  wr_state_t wr_state;
  rd_state_t rd_state;

  logic [DW-1:0] regs [C_NUM_REGS];

  // Channel beat that arrived first, held until its partner shows up.
  logic [IW-1:0] aw_idx_q;
  logic [DW-1:0] wdata_q;
  logic [SW-1:0] wstrb_q;

  // Handshake rule on every channel: a beat transfers on a rising aclk edge where both
  // valid and ready are high; a source holds valid and payload stable until that edge,
  // and all ready/valid outputs here are registered.
  logic aw_hs, w_hs, ar_hs;
  assign aw_hs = s_axi.awvalid & s_axi.awready;
  assign w_hs  = s_axi.wvalid  & s_axi.wready;
  assign ar_hs = s_axi.arvalid & s_axi.arready;

  logic [IW-1:0] aw_idx_bus, ar_idx_bus;
  assign aw_idx_bus = s_axi.awaddr[C_ADDR_WIDTH-1:LSB];
  assign ar_idx_bus = s_axi.araddr[C_ADDR_WIDTH-1:LSB];

  logic unused_bits;
  assign unused_bits = ^{s_axi.awprot, s_axi.arprot,
                         s_axi.awaddr[LSB-1:0], s_axi.araddr[LSB-1:0]};

  // Write commit selection: which address and data source depends on arrival order.
  logic                  wr_commit;
  logic [IW-1:0]         wr_idx;
  logic [DW-1:0]         wr_data;
  logic [SW-1:0]         wr_strb;
  logic [DW-1:0]         wr_mask;
  logic                  wr_in_range;
  logic [C_NUM_REGS-1:0] wr_onehot;
  logic [C_NUM_REGS-1:0] wr_sel;
  logic [1:0]            wr_resp;

  always_comb begin
    wr_commit = 1'b0;
    wr_idx    = aw_idx_bus;
    wr_data   = s_axi.wdata;
    wr_strb   = s_axi.wstrb;
    case (wr_state)
      WR_IDLE: wr_commit = aw_hs & w_hs;
      WR_ADDR: begin
        wr_commit = w_hs;
        wr_idx    = aw_idx_q;
      end
      WR_DATA: begin
        wr_commit = aw_hs;
        wr_data   = wdata_q;
        wr_strb   = wstrb_q;
      end
      default: wr_commit = 1'b0;
    endcase
  end

  always_comb begin
    wr_mask = '0;
    for (int b = 0; b < SW; b++) wr_mask[b*8 +: 8] = {8{wr_strb[b]}};
  end

  always_comb begin
    wr_in_range = ({1'b0, wr_idx} < NUM_REGS_EXT);
    wr_onehot   = '0;
    for (int i = 0; i < C_NUM_REGS; i++) wr_onehot[i] = (wr_idx == IW'(i));
    wr_sel  = wr_onehot & {C_NUM_REGS{wr_commit}};
    wr_resp = RESP_OKAY;
    if (!wr_in_range)                 wr_resp = RESP_DECERR;
    else if (|(wr_onehot & C_RO_MASK)) wr_resp = RESP_SLVERR;
  end

  // Read path mux; out-of-range indices match no register and read as zero.
  logic                  rd_in_range;
  logic [C_NUM_REGS-1:0] rd_sel;
  logic [DW-1:0]         rd_value;

  always_comb begin
    rd_in_range = ({1'b0, ar_idx_bus} < NUM_REGS_EXT);
    rd_sel      = '0;
    rd_value    = '0;
    for (int i = 0; i < C_NUM_REGS; i++) begin
      if (ar_idx_bus == IW'(i)) begin
        rd_sel[i] = 1'b1;
        rd_value  = C_RO_MASK[i] ? reg_in[i*DW +: DW] : regs[i];
      end
    end
  end

  // Register storage. W1C bits: a set pulse wins over a same-cycle clear.
  always_ff @(posedge aclk) begin
    for (int i = 0; i < C_NUM_REGS; i++) begin
      if (areset) begin
        regs[i] <= (C_RO_MASK[i] | C_W1C_MASK[i]) ? '0 : C_RESET_VALUE[i*DW +: DW];
      end else if (C_W1C_MASK[i]) begin
        regs[i] <= (regs[i] & ~({DW{wr_sel[i]}} & wr_data & wr_mask)) | evt_set[i*DW +: DW];
      end else if (!C_RO_MASK[i] && wr_sel[i]) begin
        regs[i] <= (regs[i] & ~wr_mask) | (wr_data & wr_mask);
      end
    end
  end

  always_comb begin
    reg_out = '0;
    for (int i = 0; i < C_NUM_REGS; i++)
      reg_out[i*DW +: DW] = C_RO_MASK[i] ? reg_in[i*DW +: DW] : regs[i];
  end

  // Write FSM; readies rise one cycle after entering IDLE from reset.
  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_state       <= WR_RST;
      s_axi.awready  <= 1'b0;
      s_axi.wready   <= 1'b0;
      s_axi.bvalid   <= 1'b0;
      s_axi.bresp    <= RESP_OKAY;
      aw_idx_q       <= '0;
      wdata_q        <= '0;
      wstrb_q        <= '0;
      reg_wr_pulse   <= '0;
    end else begin
      reg_wr_pulse <= '0;
      if (wr_commit) begin
        wr_state      <= WR_RESP;
        s_axi.awready <= 1'b0;
        s_axi.wready  <= 1'b0;
        s_axi.bvalid  <= 1'b1;
        s_axi.bresp   <= wr_resp;
        reg_wr_pulse  <= wr_sel & ~C_RO_MASK;
      end else begin
        case (wr_state)
          WR_RST: wr_state <= WR_IDLE;
          WR_IDLE: begin
            if (aw_hs) begin
              wr_state      <= WR_ADDR;
              aw_idx_q      <= aw_idx_bus;
              s_axi.awready <= 1'b0;
              s_axi.wready  <= 1'b1;
            end else if (w_hs) begin
              wr_state      <= WR_DATA;
              wdata_q       <= s_axi.wdata;
              wstrb_q       <= s_axi.wstrb;
              s_axi.awready <= 1'b1;
              s_axi.wready  <= 1'b0;
            end else begin
              s_axi.awready <= 1'b1;
              s_axi.wready  <= 1'b1;
            end
          end
          WR_ADDR, WR_DATA: wr_state <= wr_state;
          WR_RESP: begin
            if (s_axi.bready) begin
              wr_state      <= WR_IDLE;
              s_axi.bvalid  <= 1'b0;
              s_axi.awready <= 1'b1;
              s_axi.wready  <= 1'b1;
            end
          end
          default: wr_state <= WR_RST;
        endcase
      end
    end
  end

  // Read FSM; data and response are captured at acceptance and held until rready.
  always_ff @(posedge aclk) begin
    if (areset) begin
      rd_state      <= RD_RST;
      s_axi.arready <= 1'b0;
      s_axi.rvalid  <= 1'b0;
      s_axi.rdata   <= '0;
      s_axi.rresp   <= RESP_OKAY;
      reg_rd_pulse  <= '0;
    end else begin
      reg_rd_pulse <= '0;
      case (rd_state)
        RD_RST: rd_state <= RD_IDLE;
        RD_IDLE: begin
          if (ar_hs) begin
            rd_state      <= RD_DATA;
            s_axi.arready <= 1'b0;
            s_axi.rvalid  <= 1'b1;
            s_axi.rdata   <= rd_value;
            s_axi.rresp   <= rd_in_range ? RESP_OKAY : RESP_DECERR;
            reg_rd_pulse  <= rd_sel;
          end else begin
            s_axi.arready <= 1'b1;
          end
        end
        RD_DATA: begin
          if (s_axi.rready) begin
            rd_state      <= RD_IDLE;
            s_axi.rvalid  <= 1'b0;
            s_axi.arready <= 1'b1;
          end
        end
        default: rd_state <= RD_RST;
      endcase
    end
  end

  assign dbg_wr_state = wr_state;
  assign dbg_rd_state = rd_state;
endmodule

// File: tb/tb_axi4l_regbank.sv
// Directed bench for axi4l_regbank: 8 x 32-bit regs, reg3 W1C, reg4 RO, regs 0/1 with
// nonzero reset values.
module tb_axi4l_regbank;
  localparam int DW = 32;
  localparam int AW = 12;
  localparam int NR = 8;
  localparam logic [NR*DW-1:0] RESET_VAL = {192'h0, 32'hCAFE_0001, 32'h1234_5678};

  // ---------------- clock / reset ----------------
  logic aclk = 1'b0;
  logic areset;
  always #5 aclk = ~aclk;

  axi4l_regbank_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

  logic [NR*DW-1:0] reg_out, reg_in, evt_set;
  logic [NR-1:0]    reg_wr_pulse, reg_rd_pulse;
  logic [2:0]       dbg_wr_state;
  logic [1:0]       dbg_rd_state;

  axi4l_regbank #(
    .C_DATA_WIDTH (DW),
    .C_ADDR_WIDTH (AW),
    .C_NUM_REGS   (NR),
    .C_RO_MASK    (8'h10),
    .C_W1C_MASK   (8'h08),
    .C_RESET_VALUE(RESET_VAL)
  ) dut (
    .aclk        (aclk),
    .areset      (areset),
    .s_axi       (axi),
    .reg_out     (reg_out),
    .reg_in      (reg_in),
    .evt_set     (evt_set),
    .reg_wr_pulse(reg_wr_pulse),
    .reg_rd_pulse(reg_rd_pulse),
    .dbg_wr_state(dbg_wr_state),
    .dbg_rd_state(dbg_rd_state)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [DW-1:0]    exp_q[$];
  int               wr_pulse_cnt [NR];
  logic [NR-1:0]    last_wr_pulse, last_rd_pulse;
  logic [NR*DW-1:0] wr_evt;

  always @(negedge aclk)
    for (int i = 0; i < NR; i++) if (reg_wr_pulse[i]) wr_pulse_cnt[i]++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic write_addr_data(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                                 input logic [3:0] strb);
    logic aw_done = 1'b0, w_done = 1'b0, aw_hit, w_hit;
    axi.awaddr = addr; axi.awvalid = 1'b1;
    axi.wdata  = data; axi.wstrb   = strb; axi.wvalid = 1'b1;
    evt_set = wr_evt;
    for (int n = 0; n < 50 && !(aw_done && w_done); n++) begin
      aw_hit = axi.awvalid & axi.awready;
      w_hit  = axi.wvalid & axi.wready;
      tick();
      evt_set = '0;
      if (aw_hit) begin aw_done = 1'b1; axi.awvalid = 1'b0; end
      if (w_hit)  begin w_done  = 1'b1; axi.wvalid  = 1'b0; end
    end
    check("aw_w_accept", {aw_done, w_done}, 2'b11);
    check("bvalid_after_commit", axi.bvalid, 1'b1);
    last_wr_pulse = reg_wr_pulse;
  endtask

  task automatic write_resp(output logic [1:0] resp);
    int n = 0;
    axi.bready = 1'b1;
    while (!axi.bvalid && n < 50) begin tick(); n++; end
    check("bvalid_seen", axi.bvalid, 1'b1);
    resp = axi.bresp;
    tick();
    axi.bready = 1'b0;
    check("bvalid_drop", axi.bvalid, 1'b0);
  endtask

  task automatic axi_write(input string tag, input logic [AW-1:0] addr,
                           input logic [DW-1:0] data, input logic [3:0] strb,
                           input logic [1:0] exp_resp);
    logic [1:0] resp;
    write_addr_data(addr, data, strb);
    write_resp(resp);
    check({tag, "_bresp"}, resp, exp_resp);
  endtask

  task automatic read_addr(input logic [AW-1:0] addr);
    logic done = 1'b0, hit;
    axi.araddr = addr; axi.arvalid = 1'b1;
    for (int n = 0; n < 50 && !done; n++) begin
      hit = axi.arvalid & axi.arready;
      tick();
      if (hit) begin done = 1'b1; axi.arvalid = 1'b0; end
    end
    check("ar_accept", done, 1'b1);
    check("rvalid_after_accept", axi.rvalid, 1'b1);
    last_rd_pulse = reg_rd_pulse;
  endtask

  task automatic read_data(output logic [DW-1:0] data, output logic [1:0] resp);
    int n = 0;
    axi.rready = 1'b1;
    while (!axi.rvalid && n < 50) begin tick(); n++; end
    data = axi.rdata;
    resp = axi.rresp;
    tick();
    axi.rready = 1'b0;
    check("rvalid_drop", axi.rvalid, 1'b0);
  endtask

  task automatic axi_read_check(input string tag, input logic [AW-1:0] addr,
                                input logic [DW-1:0] exp_data, input logic [1:0] exp_resp);
    logic [DW-1:0] d;
    logic [1:0]    r;
    exp_q.push_back(exp_data);
    read_addr(addr);
    read_data(d, r);
    check({tag, "_rdata"}, d, exp_q.pop_front());
    check({tag, "_rresp"}, r, exp_resp);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0]    resp;
    logic [DW-1:0] d;
    int            base, held;
    logic          hit;

    areset = 1'b1;
    axi.awaddr = '0; axi.awprot = '0; axi.awvalid = 1'b0;
    axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 1'b0; axi.bready = 1'b0;
    axi.araddr = '0; axi.arprot = '0; axi.arvalid = 1'b0; axi.rready = 1'b0;
    reg_in = '0;
    reg_in[4*DW +: DW] = 32'h5A5A_0F0F;
    evt_set = '0;
    wr_evt  = '0;
    repeat (3) tick();

    // Reset state
    check("rst_readies", {axi.awready, axi.wready, axi.arready}, 3'b000);
    check("rst_valids", {axi.bvalid, axi.rvalid}, 2'b00);
    check("rst_rdata", axi.rdata, 32'h0);
    check("rst_pulses", {reg_wr_pulse, reg_rd_pulse}, 16'h0);
    check("rst_reg0", reg_out[0 +: DW], 32'h1234_5678);
    areset = 1'b0;
    tick();
    check("rdy_cycle1", {axi.awready, axi.wready, axi.arready}, 3'b000);
    tick();
    check("rdy_cycle2", {axi.awready, axi.wready, axi.arready}, 3'b111);
    axi_read_check("rd_reg0_rst", 12'h000, 32'h1234_5678, 2'b00);
    check("rd_pulse_reg0", last_rd_pulse, 8'h01);

    // Byte-strobed write to RW reg2
    base = wr_pulse_cnt[2];
    axi_write("wr_reg2", 12'h008, 32'hAABB_CCDD, 4'b0101, 2'b00);
    check("wr_pulse_reg2", last_wr_pulse, 8'h04);
    check("wr_pulse_cnt2", wr_pulse_cnt[2] - base, 1);
    axi_read_check("rd_reg2", 12'h008, 32'h00BB_00DD, 2'b00);
    axi_read_check("rd_reg2_offset", 12'h00B, 32'h00BB_00DD, 2'b00);

    // AW three cycles ahead of W, bready held low four cycles
    base = wr_pulse_cnt[5];
    axi.awaddr = 12'h014; axi.awvalid = 1'b1;
    hit = axi.awready;
    tick();
    axi.awvalid = 1'b0; axi.awaddr = 12'h018;
    check("aw_first_hs", hit, 1'b1);
    held = 0;
    for (int k = 0; k < 3; k++) begin
      if ({axi.awready, axi.wready, axi.bvalid} == 3'b010) held++;
      tick();
    end
    check("addr_hold_readies", held, 3);
    axi.wdata = 32'h1111_2222; axi.wstrb = 4'hF; axi.wvalid = 1'b1;
    hit = axi.wready;
    tick();
    axi.wvalid = 1'b0; axi.wdata = 32'hFFFF_FFFF;
    check("w_second_hs", hit, 1'b1);
    held = 0;
    for (int k = 0; k < 4; k++) begin
      if (axi.bvalid && !axi.awready && !axi.wready) held++;
      tick();
    end
    check("b_held_aw_first", held, 4);
    write_resp(resp);
    check("aw_first_bresp", resp, 2'b00);
    check("aw_first_reg5", reg_out[5*DW +: DW], 32'h1111_2222);

    // W three cycles ahead of AW
    axi.wdata = 32'h3333_4444; axi.wstrb = 4'b0011; axi.wvalid = 1'b1;
    hit = axi.wready;
    tick();
    axi.wvalid = 1'b0; axi.wdata = 32'hFFFF_FFFF; axi.wstrb = 4'hF;
    check("w_first_hs", hit, 1'b1);
    held = 0;
    for (int k = 0; k < 3; k++) begin
      if ({axi.awready, axi.wready, axi.bvalid} == 3'b100) held++;
      tick();
    end
    check("data_hold_readies", held, 3);
    axi.awaddr = 12'h014; axi.awvalid = 1'b1;
    hit = axi.awready;
    tick();
    axi.awvalid = 1'b0;
    check("aw_second_hs", hit, 1'b1);
    held = 0;
    for (int k = 0; k < 4; k++) begin
      if (axi.bvalid && !axi.awready && !axi.wready) held++;
      tick();
    end
    check("b_held_w_first", held, 4);
    write_resp(resp);
    check("w_first_bresp", resp, 2'b00);
    check("wr_pulse_cnt5", wr_pulse_cnt[5] - base, 2);
    axi_read_check("rd_reg5", 12'h014, 32'h1111_4444, 2'b00);

    // W1C reg3: event sticks, clear and set in same cycle
    evt_set[3*DW +: DW] = 32'h8;
    tick();
    evt_set = '0;
    check("w1c_evt3", reg_out[3*DW +: DW], 32'h8);
    wr_evt[3*DW +: DW] = 32'h20;
    axi_write("w1c_clr3", 12'h00C, 32'h8, 4'hF, 2'b00);
    check("w1c_wr_pulse", last_wr_pulse, 8'h08);
    axi_read_check("rd_w1c_a", 12'h00C, 32'h20, 2'b00);
    wr_evt[3*DW +: DW] = 32'h2;
    axi_write("w1c_setclr1", 12'h00C, 32'h2, 4'hF, 2'b00);
    wr_evt = '0;
    axi_read_check("rd_w1c_b", 12'h00C, 32'h22, 2'b00);
    axi_write("w1c_clr5", 12'h00C, 32'h20, 4'hF, 2'b00);
    axi_read_check("rd_w1c_c", 12'h00C, 32'h2, 2'b00);

    // RO reg4 and out-of-range index
    axi_read_check("rd_ro4", 12'h010, 32'h5A5A_0F0F, 2'b00);
    check("rd_pulse_reg4", last_rd_pulse, 8'h10);
    axi_write("wr_ro4", 12'h010, 32'hFFFF_FFFF, 4'hF, 2'b10);
    check("ro_no_wr_pulse", last_wr_pulse, 8'h00);
    reg_in[4*DW +: DW] = 32'h0102_0304;
    axi_read_check("rd_ro4_live", 12'h010, 32'h0102_0304, 2'b00);
    axi_write("wr_oor", 12'h020, 32'h1234_5678, 4'hF, 2'b11);
    check("oor_no_wr_pulse", last_wr_pulse, 8'h00);
    axi_read_check("rd_oor", 12'h020, 32'h0, 2'b11);
    check("oor_no_rd_pulse", last_rd_pulse, 8'h00);
    axi_write("wr_last", 12'h01C, 32'h7777_0007, 4'hF, 2'b00);
    axi_read_check("rd_last", 12'h01C, 32'h7777_0007, 2'b00);

    // Read and write of reg6 in the same cycle
    axi.awaddr = 12'h018; axi.wdata = 32'h6666_0006; axi.wstrb = 4'hF;
    axi.awvalid = 1'b1; axi.wvalid = 1'b1;
    axi.araddr = 12'h018; axi.arvalid = 1'b1;
    tick();
    axi.awvalid = 1'b0; axi.wvalid = 1'b0; axi.arvalid = 1'b0;
    check("same_cyc_rvalid", axi.rvalid, 1'b1);
    check("same_cyc_rdata_old", axi.rdata, 32'h0);
    check("same_cyc_reg6_new", reg_out[6*DW +: DW], 32'h6666_0006);
    write_resp(resp);
    check("same_cyc_bresp", resp, 2'b00);
    read_data(d, resp);

    // Reset in the middle of pending B and R
    write_addr_data(12'h000, 32'hDEAD_BEEF, 4'hF);
    check("mid_reg0_written", reg_out[0 +: DW], 32'hDEAD_BEEF);
    read_addr(12'h004);
    areset = 1'b1;
    tick();
    check("mid_rst_valids", {axi.bvalid, axi.rvalid}, 2'b00);
    check("mid_rst_reg0", reg_out[0 +: DW], 32'h1234_5678);
    check("mid_rst_reg2", reg_out[2*DW +: DW], 32'h0);
    check("mid_rst_reg3", reg_out[3*DW +: DW], 32'h0);
    check("mid_rst_reg5", reg_out[5*DW +: DW], 32'h0);
    areset = 1'b0;
    tick();
    tick();
    axi_write("wr_after_rst", 12'h004, 32'h0F00_0000, 4'b1000, 2'b00);
    axi_read_check("rd_after_rst1", 12'h004, 32'h0FFE_0001, 2'b00);
    axi_read_check("rd_after_rst0", 12'h000, 32'h1234_5678, 2'b00);

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/axi4l_regbank.md
# axi4l_regbank

Parametrised AXI4-Lite slave register bank, successor to the fixed two-register IPIF. It provides up to C_NUM_REGS word registers at a contiguous, word-stride address map. Each register has a per-register mode: read/write control, read-only status, or write-1-to-clear sticky event. It sits between the AXI interconnect and fabric logic, exporting control registers and per-register access strobes, and importing status and event inputs.

## Interface

- C_DATA_WIDTH, 32: AXI data width and register width; 32 or 64.
- C_ADDR_WIDTH, 12: significant AXI address bits; upper address bits are ignored.
- C_NUM_REGS, 8: number of registers, 1..2**(C_ADDR_WIDTH-log2(C_DATA_WIDTH/8)).
- C_RO_MASK, 0: bit i=1 makes register i read-only; its read value is reg_in slice i.
- C_W1C_MASK, 0: bit i=1 makes register i sticky write-1-to-clear; must not overlap C_RO_MASK.
- C_RESET_VALUE, 0: flattened C_NUM_REGS*C_DATA_WIDTH reset values for RW registers.

- aclk  in  1  clock.
- areset  in  1  synchronous reset, active-high.
- s_axi_aw*/w*/b*/ar*/r*  standard AXI4-Lite slave channels; awaddr/araddr are C_ADDR_WIDTH bits; wdata/rdata are C_DATA_WIDTH bits; wstrb is C_DATA_WIDTH/8 bits; awprot/arprot are accepted and ignored.
- reg_out  out  C_NUM_REGS*C_DATA_WIDTH  current value of every register, slice i = register i.
- reg_in  in  C_NUM_REGS*C_DATA_WIDTH  status values for RO registers; slices of other registers are unused.
- evt_set  in  C_NUM_REGS*C_DATA_WIDTH  per-bit set pulses for W1C registers.
- reg_wr_pulse  out  C_NUM_REGS  one-cycle pulse when a write to register i commits.
- reg_rd_pulse  out  C_NUM_REGS  one-cycle pulse when a read of register i is accepted.

## Operation

- Decode:
  - index = addr[C_ADDR_WIDTH-1 : log2(C_DATA_WIDTH/8)]; the low byte-offset bits are ignored.
  - index >= C_NUM_REGS: DECERR; read data is 0; no state changes.
- Write FSM states: RST, IDLE, ADDR (address held, waiting for data), DATA (data held, waiting for address), RESP.
  - RST → IDLE unconditionally.
  - IDLE → RESP on awvalid&wvalid; → ADDR on awvalid only; → DATA on wvalid only.
  - ADDR → RESP on wvalid.
  - DATA → RESP on awvalid.
  - RESP → IDLE on bready.
  - The channel whose beat arrived first is registered internally; the bus value is not reused.
- Write commit happens in the cycle the FSM enters RESP.
  - RW register: byte lanes with wstrb=1 are updated.
  - W1C register: each bit with wdata=1 in a strobed lane is cleared; BRESP OKAY.
  - RO register: no update; BRESP SLVERR; reg_wr_pulse is still not asserted.
  - Out of range: BRESP DECERR.
- W1C next value = (cur & ~clr) | evt_set. A set and a clear of the same bit in the same cycle leave the bit at 1.
- Read FSM states: RST → IDLE; IDLE → DATA on arvalid; DATA → IDLE on rready.
  - rdata and rresp are captured at acceptance, from the pre-write value of the same cycle.
  - RRESP is OKAY in range, DECERR out of range.
- The read and write paths are independent. A read and a write to the same register in the same cycle: the read returns the old value and the write lands.
- reg_rd_pulse[i] is asserted with read acceptance. Fabric uses it for clear-on-read of its own counters.

## Timing

- Reset values while areset is high and on the cycle after it falls:
  - all ready, valid and resp outputs 0;
  - rdata 0;
  - pulses 0;
  - RW registers = C_RESET_VALUE;
  - W1C registers = 0.
- awready, wready and arready rise 2 cycles after areset falls (RST → IDLE → registered ready).
- All AXI outputs are registered.
- Handshake cycles and ready timing:
  - awready is high in IDLE and DATA.
  - wready is high in IDLE and ADDR.
  - arready is high in IDLE.
  - Both write readies drop in the cycle after entry into RESP.
- Write latency: AW and W in the same edge N → register updated and bvalid high after edge N. bvalid is held until bready is sampled at edge M; readies return after M. The best write interval is 2 cycles.
- Read latency: arvalid&arready at edge N → rvalid/rdata/rresp valid after N, held stable until rready. The best read interval is 2 cycles.
- reg_wr_pulse is asserted for the single cycle after commit, coincident with the first bvalid cycle. reg_rd_pulse is asserted for the single cycle after read acceptance.
- areset asserted mid-transaction aborts it immediately:
  - bvalid and rvalid drop the next cycle;
  - the pending captured address/data is discarded;
  - register contents return to reset values.

## Test plan

- Reset release: readies are 0 for 2 cycles then 1; read of reg 0 with C_RESET_VALUE slice 0 = 0x1234_5678 → RDATA 0x1234_5678, RRESP 00.
- Write reg 2 with wdata 0xAABB_CCDD and wstrb 0101, where the register was 0 → reads back 0x00BB_00DD; BRESP 00; reg_wr_pulse[2] for 1 cycle.
- AW three cycles before W, then W three cycles before AW, with bready held low for 4 cycles → each write commits exactly once; bvalid is held; no second AW or W is accepted until B completes.
- W1C reg: evt_set bit 3 pulses; write 0x8 in the same cycle as evt_set bit 5 → reads 0x20. In a separate step, clear and set bit 1 in the same cycle → bit 1 = 1.
- Write to RO reg → BRESP 10, register unchanged. Write and read to index C_NUM_REGS → BRESP 11 and RRESP 11, RDATA 0.
- areset pulsed while bvalid is high and while rvalid is high → both drop next cycle; RW registers return to C_RESET_VALUE; normal traffic resumes afterwards.
